// File: rtl/press_classifier_pkg.sv
// Shared types and elaboration-time parameter checks for the pushbutton press classifier.
package press_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        REPEAT  = 2'd2,
        LOCKOUT = 2'd3
    } press_state_t;

    // True when the timing parameters are mutually consistent and every terminal count fits.
    function automatic bit press_params_ok(input int unsigned cnt_w,
                                           input int unsigned long_c,
                                           input int unsigned rep_c,
                                           input int unsigned deb_c);
        longint unsigned max_c;
        max_c = longint'(long_c);
        if (longint'(rep_c) > max_c) max_c = longint'(rep_c);
        if (longint'(deb_c) > max_c) max_c = longint'(deb_c);
        return (deb_c >= 1) && (deb_c < long_c) && (rep_c >= 1) &&
               (cnt_w >= 1) && (cnt_w < 63) && ((max_c - 1) < (64'd1 << cnt_w));
    endfunction

endpackage

// File: rtl/press_classifier_counter.sv
// Clearable, enabled up-counter with an equality compare against a supplied terminal value.
module cycle_counter #(
    parameter int unsigned CNT_W = 27
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] i_term,
    output logic [CNT_W-1:0] o_count,
    output logic             o_at_term
);

    logic [CNT_W-1:0] r_count;

    // Clear has priority so a state change can restart timing in the same cycle it is enabled.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count   = r_count;
    assign o_at_term = (r_count == i_term);

endmodule

// File: rtl/press_classifier.sv
// Classifies synchronized button edge pulses into short press, long press and auto-repeat events,
// with a post-release lockout that masks contact bounce.
module press_classifier
    import press_pkg::*;
#(
    parameter int unsigned LONG_CYCLES     = 100_000_000,
    parameter int unsigned REPEAT_CYCLES   = 25_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W           = 27
) (
    input  logic clk,
    input  logic reset,
    input  logic press_rise,
    input  logic press_fall,
    output logic short_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);

    localparam bit PARAMS_OK = press_params_ok(CNT_W, LONG_CYCLES, REPEAT_CYCLES, DEBOUNCE_CYCLES);

    if (!PARAMS_OK) begin : g_param_check
        $error("press_classifier: inconsistent timing parameters or CNT_W too narrow");
    end

    localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_TERM  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_MIN   = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] REP_TERM  = CNT_W'(REPEAT_CYCLES - 1);

    press_state_t     r_state;
    press_state_t     w_state_nxt;
    logic             r_short;
    logic             r_long;
    logic             r_repeat;
    logic             w_short_nxt;
    logic             w_long_nxt;
    logic             w_repeat_nxt;

    logic             w_hold_clr;
    logic             w_hold_en;
    logic [CNT_W-1:0] w_hold_term;
    logic [CNT_W-1:0] w_hold_cnt;
    logic             w_hold_at_term;
    logic             w_rep_clr;
    logic             w_rep_en;
    logic [CNT_W-1:0] w_rep_cnt;
    logic             w_rep_at_term;
    logic             w_rep_wrap;
    logic             w_hold_valid;

    // The hold counter doubles as the lockout timer; PRESSED and LOCKOUT never overlap.
    assign w_hold_term = (r_state == LOCKOUT) ? DEB_TERM : LONG_TERM;

    cycle_counter #(
        .CNT_W(CNT_W)
    ) u_hold_cnt (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_hold_clr),
        .i_enable (w_hold_en),
        .i_term   (w_hold_term),
        .o_count  (w_hold_cnt),
        .o_at_term(w_hold_at_term)
    );

    cycle_counter #(
        .CNT_W(CNT_W)
    ) u_rep_cnt (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_rep_clr),
        .i_enable (w_rep_en),
        .i_term   (REP_TERM),
        .o_count  (w_rep_cnt),
        .o_at_term(w_rep_at_term)
    );

    assign w_hold_valid = (w_hold_cnt >= DEB_MIN);
    // Out-of-range count (e.g. after an upset) wraps like a terminal count instead of running on.
    assign w_rep_wrap   = w_rep_at_term || (w_rep_cnt > REP_TERM);

    always_comb begin
        w_state_nxt  = r_state;
        w_short_nxt  = 1'b0;
        w_long_nxt   = 1'b0;
        w_repeat_nxt = 1'b0;
        w_hold_clr   = 1'b0;
        w_hold_en    = 1'b0;
        w_rep_clr    = 1'b0;
        w_rep_en     = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_hold_clr = 1'b1;
                w_rep_clr  = 1'b1;
                if (press_rise && !press_fall) begin
                    w_state_nxt = PRESSED;
                end
            end
            PRESSED: begin
                if (press_fall) begin
                    w_hold_clr = 1'b1;
                    if (w_hold_valid) begin
                        w_short_nxt = 1'b1;
                        w_state_nxt = LOCKOUT;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (w_hold_at_term) begin
                    w_long_nxt  = 1'b1;
                    w_hold_clr  = 1'b1;
                    w_rep_clr   = 1'b1;
                    w_state_nxt = REPEAT;
                end else begin
                    w_hold_en = 1'b1;
                end
            end
            REPEAT: begin
                if (press_fall) begin
                    w_hold_clr  = 1'b1;
                    w_rep_clr   = 1'b1;
                    w_state_nxt = LOCKOUT;
                end else if (w_rep_wrap) begin
                    w_repeat_nxt = 1'b1;
                    w_rep_clr    = 1'b1;
                end else begin
                    w_rep_en = 1'b1;
                end
            end
            LOCKOUT: begin
                if (w_hold_at_term) begin
                    w_hold_clr  = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_hold_en = 1'b1;
                end
            end
            default: begin
                w_hold_clr  = 1'b1;
                w_rep_clr   = 1'b1;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_repeat <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_short  <= w_short_nxt;
            r_long   <= w_long_nxt;
            r_repeat <= w_repeat_nxt;
        end
    end

    assign short_press  = r_short;
    assign long_press   = r_long;
    assign repeat_pulse = r_repeat;
    assign held         = ((r_state == PRESSED) && w_hold_valid) || (r_state == REPEAT);

endmodule

// File: tb/tb_press_classifier.sv
// Directed bench for press_classifier with LONG=20, REPEAT=5, DEBOUNCE=3; cycle 0 is the first
// cycle with reset low, inputs driven in cycle c are sampled at the edge that starts cycle c+1.
module tb_press_classifier;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic press_rise = 1'b0;
    logic press_fall = 1'b0;
    logic short_press;
    logic long_press;
    logic repeat_pulse;
    logic held;

    int checks = 0;
    int errors = 0;

    press_classifier #(
        .LONG_CYCLES    (20),
        .REPEAT_CYCLES  (5),
        .DEBOUNCE_CYCLES(3),
        .CNT_W          (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .press_rise  (press_rise),
        .press_fall  (press_fall),
        .short_press (short_press),
        .long_press  (long_press),
        .repeat_pulse(repeat_pulse),
        .held        (held)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        press_rise = 1'b0;
        press_fall = 1'b0;
        repeat (5) step();
        reset = 1'b0;
    endtask

    // Vectors below are {short_press, long_press, repeat_pulse, held}.
    task automatic test_reset();
        logic [3:0] got;
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            press_rise = 1'($urandom_range(0, 1));
            press_fall = 1'($urandom_range(0, 1));
            step();
            got = {short_press, long_press, repeat_pulse, held};
            checks++;
            if (got !== 4'b0000) begin
                errors++;
                $display("FAIL reset_hold step %0d: got %b expected 0000", c, got);
            end
        end
        reset      = 1'b0;
        press_rise = 1'b0;
        press_fall = 1'b0;
        for (int c = 0; c <= 5; c++) begin
            got = {short_press, long_press, repeat_pulse, held};
            checks++;
            if (got !== 4'b0000) begin
                errors++;
                $display("FAIL reset_release cycle %0d: got %b expected 0000", c, got);
            end
            step();
        end
    endtask

    task automatic test_short_press();
        logic [3:0] got;
        logic [3:0] exp;
        do_reset();
        for (int c = 0; c <= 24; c++) begin
            press_rise = (c == 10);
            press_fall = (c == 18);
            exp = {c == 19, 1'b0, 1'b0, (c >= 14) && (c <= 18)};
            got = {short_press, long_press, repeat_pulse, held};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL short_press cycle %0d: got %b expected %b", c, got, exp);
            end
            step();
        end
        press_rise = 1'b0;
        press_fall = 1'b0;
    endtask

    task automatic test_glitch();
        logic [3:0] got;
        logic [3:0] exp;
        do_reset();
        for (int c = 0; c <= 26; c++) begin
            press_rise = (c == 10) || (c == 13);
            press_fall = (c == 12) || (c == 20);
            // Second press is accepted at 13, so hold reaches 3 at cycle 17; release at 20.
            exp = {c == 21, 1'b0, 1'b0, (c >= 17) && (c <= 20)};
            got = {short_press, long_press, repeat_pulse, held};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL glitch cycle %0d: got %b expected %b", c, got, exp);
            end
            step();
        end
        press_rise = 1'b0;
        press_fall = 1'b0;
    endtask

    task automatic test_long_repeat();
        logic [3:0] got;
        logic [3:0] exp;
        do_reset();
        for (int c = 0; c <= 58; c++) begin
            press_rise = (c == 10) || (c == 49);
            press_fall = (c == 45) || (c == 55);
            // Fall at 45 coincides with the next repeat terminal count, so no pulse at 46.
            // Lockout 46-48; the rise at 49 is accepted and released with hold 5 at 55.
            exp = {c == 56, c == 31, (c == 36) || (c == 41),
                   ((c >= 14) && (c <= 45)) || ((c >= 53) && (c <= 55))};
            got = {short_press, long_press, repeat_pulse, held};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL long_repeat cycle %0d: got %b expected %b", c, got, exp);
            end
            step();
        end
        press_rise = 1'b0;
        press_fall = 1'b0;
    endtask

    task automatic test_lockout();
        logic [3:0] got;
        logic [3:0] exp;
        do_reset();
        for (int c = 0; c <= 36; c++) begin
            press_rise = (c == 10) || (c == 20) || (c == 22);
            press_fall = (c == 18) || (c == 30);
            exp = {(c == 19) || (c == 31), 1'b0, 1'b0,
                   ((c >= 14) && (c <= 18)) || ((c >= 26) && (c <= 30))};
            got = {short_press, long_press, repeat_pulse, held};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL lockout cycle %0d: got %b expected %b", c, got, exp);
            end
            step();
        end
        press_rise = 1'b0;
        press_fall = 1'b0;
    endtask

    task automatic test_fall_boundaries();
        logic [3:0] got;
        logic [3:0] exp;
        int         fall_c [3] = '{13, 14, 30};
        for (int k = 0; k < 3; k++) begin
            do_reset();
            for (int c = 0; c <= 36; c++) begin
                press_rise = (c == 10);
                press_fall = (c == fall_c[k]);
                // hold_cnt at the fall is fall_c-11: 2 is a glitch, 3 is the minimum short,
                // 19 coincides with the long threshold and the fall must win.
                exp = {(fall_c[k] >= 14) && (c == fall_c[k] + 1), 1'b0, 1'b0,
                       (c >= 14) && (c <= fall_c[k])};
                got = {short_press, long_press, repeat_pulse, held};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL fall_at_%0d cycle %0d: got %b expected %b",
                             fall_c[k], c, got, exp);
                end
                step();
            end
        end
        press_rise = 1'b0;
        press_fall = 1'b0;
    endtask

    task automatic test_both_edges();
        logic [3:0] got;
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            press_rise = (c == 10);
            press_fall = (c == 10);
            got = {short_press, long_press, repeat_pulse, held};
            checks++;
            if (got !== 4'b0000) begin
                errors++;
                $display("FAIL both_edges cycle %0d: got %b expected 0000", c, got);
            end
            step();
        end
        press_rise = 1'b0;
        press_fall = 1'b0;
    endtask

    task automatic test_reset_mid_repeat();
        logic [3:0] got;
        logic [3:0] exp;
        do_reset();
        for (int c = 0; c <= 55; c++) begin
            press_rise = (c == 10);
            press_fall = (c == 45);
            reset      = (c == 33);
            exp = {1'b0, c == 31, 1'b0, (c >= 14) && (c <= 33)};
            got = {short_press, long_press, repeat_pulse, held};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_mid_repeat cycle %0d: got %b expected %b", c, got, exp);
            end
            step();
        end
        reset      = 1'b0;
        press_rise = 1'b0;
        press_fall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_short_press();
        test_glitch();
        test_long_repeat();
        test_lockout();
        test_fall_boundaries();
        test_both_edges();
        test_reset_mid_repeat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
